// File: rtl/arith_add_and_div_32.sv
// Clocked 32-bit ADD / AND / signed DIV core with a packed 64-bit result.
// ADD and AND finish one cycle after Start; DIV is a 32-step restoring divider on
// operand magnitudes, with sign fix-up and divide-by-zero handling in a final cycle.
module arith_add_and_div_32 #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DIV_STEPS = 32
) (
  input  logic               Clock,
  input  logic               Clear,
  input  logic               Start,
  input  logic [1:0]         Op,
  input  logic [WIDTH-1:0]   Ain,
  input  logic [WIDTH-1:0]   Bin,
  input  logic               Cin,
  output logic [2*WIDTH-1:0] Zout,
  output logic               Cout,
  output logic               Busy,
  output logic               Done,
  output logic               DivZero
);

  localparam int unsigned CntW = $clog2(DIV_STEPS + 1);

  typedef enum logic [0:0] {StIdle, StDiv} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;   // raw dividend, returned as remainder on divide-by-zero
  logic               q_neg_q, q_neg_d;
  logic               r_neg_q, r_neg_d;
  logic               dz_q, dz_d;
  logic [2*WIDTH-1:0] zout_q, zout_d;
  logic               cout_q, cout_d;
  logic               done_q, done_d;
  logic               divzero_q, divzero_d;

  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     shift, trial;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Fixed datapath pieces shared by the decode and the divider step
  always_comb begin
    sum     = {1'b0, Ain} + {1'b0, Bin} + {{WIDTH{1'b0}}, Cin};
    a_abs   = Ain[WIDTH-1] ? (~Ain + 1'b1) : Ain;
    b_abs   = Bin[WIDTH-1] ? (~Bin + 1'b1) : Bin;
    shift   = {rem_q, quo_q[WIDTH-1]};
    trial   = shift - {1'b0, dvs_q};
    quo_fix = q_neg_q ? (~quo_q + 1'b1) : quo_q;
    rem_fix = r_neg_q ? (~rem_q + 1'b1) : rem_q;
  end

  // Next-state: op decode in idle, one quotient bit per cycle while dividing, then fix-up
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    dvd_d     = dvd_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    dz_d      = dz_q;
    zout_d    = zout_q;
    cout_d    = cout_q;
    done_d    = 1'b0;
    divzero_d = divzero_q;

    unique case (state_q)
      StIdle: begin
        if (Start) begin
          unique case (Op)
            2'b00: begin
              zout_d    = {{WIDTH{1'b0}}, sum[WIDTH-1:0]};
              cout_d    = sum[WIDTH];
              done_d    = 1'b1;
              divzero_d = 1'b0;
            end
            2'b01: begin
              zout_d    = {{WIDTH{1'b0}}, Ain & Bin};
              cout_d    = 1'b0;
              done_d    = 1'b1;
              divzero_d = 1'b0;
            end
            2'b10: begin
              state_d = StDiv;
              cnt_d   = '0;
              rem_d   = '0;
              quo_d   = a_abs;
              dvs_d   = b_abs;
              dvd_d   = Ain;
              q_neg_d = Ain[WIDTH-1] ^ Bin[WIDTH-1];
              r_neg_d = Ain[WIDTH-1];
              dz_d    = (Bin == '0);
            end
            default: begin
              zout_d    = '0;
              cout_d    = 1'b0;
              done_d    = 1'b1;
              divzero_d = 1'b0;
            end
          endcase
        end
      end
      StDiv: begin
        if (cnt_q != CntW'(DIV_STEPS)) begin
          // trial MSB set means the shifted remainder was below the divisor: restore
          if (trial[WIDTH]) begin
            rem_d = shift[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end else begin
            rem_d = trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end
          cnt_d = cnt_q + 1'b1;
        end else begin
          state_d   = StIdle;
          done_d    = 1'b1;
          cout_d    = 1'b0;
          divzero_d = dz_q;
          zout_d    = dz_q ? {dvd_q, {WIDTH{1'b1}}} : {rem_fix, quo_fix};
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and result registers; Clear aborts any division without producing a result
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      dvd_q     <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      dz_q      <= 1'b0;
      zout_q    <= '0;
      cout_q    <= 1'b0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      dvd_q     <= dvd_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      dz_q      <= dz_d;
      zout_q    <= zout_d;
      cout_q    <= cout_d;
      done_q    <= done_d;
      divzero_q <= divzero_d;
    end
  end

  assign Zout    = zout_q;
  assign Cout    = cout_q;
  assign Busy    = (state_q == StDiv);
  assign Done    = done_q;
  assign DivZero = divzero_q;

endmodule

// File: tb/tb_arith_add_and_div_32.sv
// Scoreboard bench for arith_add_and_div_32: expected results are queued when an op is
// started and compared whenever Done is seen.
module tb_arith_add_and_div_32;

  typedef struct packed {
    logic [63:0] z;
    logic        c;
    logic        dz;
  } exp_t;

  logic        Clock = 1'b0;
  logic        Clear;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] Ain;
  logic [31:0] Bin;
  logic        Cin;
  logic [63:0] Zout;
  logic        Cout;
  logic        Busy;
  logic        Done;
  logic        DivZero;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  arith_add_and_div_32 dut (
    .Clock   (Clock),
    .Clear   (Clear),
    .Start   (Start),
    .Op      (Op),
    .Ain     (Ain),
    .Bin     (Bin),
    .Cin     (Cin),
    .Zout    (Zout),
    .Cout    (Cout),
    .Busy    (Busy),
    .Done    (Done),
    .DivZero (DivZero)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic cin);
    exp_t               m;
    logic [32:0]        s;
    logic signed [31:0] sa, sbv;
    logic [31:0]        q, r;
    m = '0;
    case (op)
      2'b00: begin
        s   = {1'b0, a} + {1'b0, b} + {32'd0, cin};
        m.z = {32'd0, s[31:0]};
        m.c = s[32];
      end
      2'b01: m.z = {32'd0, a & b};
      2'b10: begin
        sa  = a;
        sbv = b;
        if (b == 32'd0) begin
          q    = 32'hFFFFFFFF;
          r    = a;
          m.dz = 1'b1;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          q = 32'h80000000;
          r = 32'd0;
        end else begin
          q = sa / sbv;
          r = sa % sbv;
        end
        m.z = {r, q};
      end
      default: m = '0;
    endcase
    return m;
  endfunction

  // Scoreboard consumer: every Done must match the oldest outstanding expectation
  always @(negedge Clock) begin
    if (Done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", {63'd0, Done}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("zout", Zout, e.z);
        chk("cout", {63'd0, Cout}, {63'd0, e.c});
        chk("divzero", {63'd0, DivZero}, {63'd0, e.dz});
      end
    end
  end

  // Start one op; optionally disturb operands and pulse a blocked Start while dividing
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input bit disturb);
    int          lat;
    int          exp_lat;
    logic [63:0] z_before;
    exp_lat = (op == 2'b10) ? 33 : 0;
    @(negedge Clock);
    z_before = Zout;
    Start = 1'b1;
    Op    = op;
    Ain   = a;
    Bin   = b;
    Cin   = cin;
    sb.push_back(model(op, a, b, cin));
    @(posedge Clock);
    #1;
    Start = 1'b0;
    if (op == 2'b10) chk("busy_set", {63'd0, Busy}, 64'd1);
    lat = 0;
    while (!Done && lat < 40) begin
      if (disturb && lat == 5) begin
        Start = 1'b1;
        Op    = 2'b01;
        Ain   = $urandom;
        Bin   = $urandom;
      end
      if (disturb && lat == 6) Start = 1'b0;
      if (op == 2'b10 && lat == 10) chk("zout_stable", Zout, z_before);
      @(posedge Clock);
      #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    if (op == 2'b10) chk("busy_clr", {63'd0, Busy}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Clear = 1'b1;
    Start = 1'b0;
    Op    = 2'b00;
    Ain   = '0;
    Bin   = '0;
    Cin   = 1'b0;
    #12;
    chk("rst_zout", Zout, 64'd0);
    chk("rst_flags", {60'd0, Cout, Busy, Done, DivZero}, 64'd0);
    @(negedge Clock);
    Clear = 1'b0;

    // Async clear in the middle of a cycle wipes a live result
    do_op(2'b00, 32'd3, 32'd4, 1'b1, 1'b0);
    @(posedge Clock);
    #2;
    Clear = 1'b1;
    #1;
    chk("aclr_zout", Zout, 64'd0);
    chk("aclr_flags", {60'd0, Cout, Busy, Done, DivZero}, 64'd0);
    @(negedge Clock);
    Clear = 1'b0;

    do_op(2'b00, 32'd5, 32'd7, 1'b0, 1'b0);
    @(posedge Clock);
    #1;
    chk("done_pulse", {63'd0, Done}, 64'd0);
    do_op(2'b00, 32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0);
    do_op(2'b01, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 1'b0);
    do_op(2'b11, 32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0);
    do_op(2'b10, 32'd100, 32'd7, 1'b0, 1'b0);
    do_op(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
    do_op(2'b10, 32'd9, 32'd0, 1'b0, 1'b0);
    do_op(2'b00, 32'd1, 32'd1, 1'b0, 1'b0);
    do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1);
    do_op(2'b10, 32'd7, 32'hFFFFFFFE, 1'b0, 1'b0);

    // Clear partway through a division: no result, divider returns to idle
    @(negedge Clock);
    Start = 1'b1;
    Op    = 2'b10;
    Ain   = 32'd50;
    Bin   = 32'd3;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    repeat (9) @(posedge Clock);
    #2;
    Clear = 1'b1;
    #1;
    chk("div_clr_busy", {63'd0, Busy}, 64'd0);
    chk("div_clr_done", {63'd0, Done}, 64'd0);
    chk("div_clr_zout", Zout, 64'd0);
    @(negedge Clock);
    Clear = 1'b0;
    repeat (40) @(posedge Clock);
    do_op(2'b10, 32'd20, 32'd4, 1'b0, 1'b0);

    // Random mix, issued back-to-back
    for (int i = 0; i < 12; i++) begin
      logic [1:0] rop;
      rop = 2'($urandom_range(0, 3));
      do_op(rop, $urandom, (i == 3) ? 32'd0 : $urandom_range(0, 7) == 0 ? 32'd5 : $urandom,
            1'($urandom), 1'b0);
    end

    repeat (3) @(posedge Clock);
    chk("sb_drain", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
